// File: rtl/parking_pkg.sv
// parking_pkg: lane state encoding, sensor-pair codes and a popcount helper
package parking_pkg;
  typedef enum logic [2:0] {IDLE, IN_A, IN_B, IN_C, OUT_A, OUT_B, OUT_C} lane_state_t;
  localparam logic [1:0] CLEAR = 2'b00;
  localparam logic [1:0] OUT_ONLY = 2'b10;
  localparam logic [1:0] IN_ONLY = 2'b01;
  localparam logic [1:0] BOTH = 2'b11;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    popcount = '0;
    for (int i = 0; i < 8; i++) popcount += {3'b0, v[i]};
  endfunction
endpackage

// File: rtl/lane_fsm.sv
// lane_fsm: one lane's synchroniser, debounce filter and entry/exit sequence tracker
module lane_fsm
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic outer,
  input  logic inner,
  output logic enter,
  output logic exit,
  output logic illegal
);
  localparam int RW = $clog2(DEBOUNCE + 1);
  logic [1:0] s1, s2, filt, p;
  logic [1:0][RW-1:0] run;
  lane_state_t state;
  // p is the value the filter adopts on this edge, so the FSM moves on the same edge
  always_comb begin
    p = filt;
    for (int b = 0; b < 2; b++)
      p[b] = (s2[b] != filt[b] && run[b] == RW'(DEBOUNCE - 1)) ? s2[b] : filt[b];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      run <= '0;
    end else begin
      s1 <= {outer, inner};
      s2 <= s1;
      filt <= p;
      for (int b = 0; b < 2; b++)
        run[b] <= (s2[b] == filt[b] || p[b] != filt[b]) ? '0 : run[b] + RW'(1);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit <= 1'b0;
      illegal <= 1'b0;
    end else begin
      enter <= 1'b0;
      exit <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          state <= (p == OUT_ONLY) ? IN_A : (p == IN_ONLY) ? OUT_A : IDLE;
          illegal <= p == BOTH;
        end
        IN_A: begin
          state <= (p == BOTH) ? IN_B : (p == OUT_ONLY) ? IN_A : IDLE;
          illegal <= p == IN_ONLY;
        end
        IN_B: begin
          state <= (p == IN_ONLY) ? IN_C : (p == OUT_ONLY) ? IN_A : (p == BOTH) ? IN_B : IDLE;
          illegal <= p == CLEAR;
        end
        IN_C: begin
          state <= (p == BOTH) ? IN_B : (p == IN_ONLY) ? IN_C : IDLE;
          enter <= p == CLEAR;
          illegal <= p == OUT_ONLY;
        end
        OUT_A: begin
          state <= (p == BOTH) ? OUT_B : (p == IN_ONLY) ? OUT_A : IDLE;
          illegal <= p == OUT_ONLY;
        end
        OUT_B: begin
          state <= (p == OUT_ONLY) ? OUT_C : (p == IN_ONLY) ? OUT_A : (p == BOTH) ? OUT_B : IDLE;
          illegal <= p == CLEAR;
        end
        OUT_C: begin
          state <= (p == BOTH) ? OUT_B : (p == OUT_ONLY) ? OUT_C : IDLE;
          exit <= p == CLEAR;
          illegal <= p == IN_ONLY;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/parking_lot_monitor.sv
// parking_lot_monitor: multi-lane entry/exit tracker driving a saturating occupancy count
module parking_lot_monitor
  import parking_pkg::*;
#(
  parameter int N_LANES = 2,
  parameter int CAPACITY = 16,
  parameter int DEBOUNCE = 4,
  localparam int CNT_W = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] outer,
  input  logic [N_LANES-1:0] inner,
  input  logic               clear_fault,
  output logic [N_LANES-1:0] enter,
  output logic [N_LANES-1:0] exit,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow,
  output logic [N_LANES-1:0] fault
);
  localparam int SW = CNT_W + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);
  logic [N_LANES-1:0] illegal;
  logic signed [SW-1:0] nxt;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_fsm #(.DEBOUNCE(DEBOUNCE)) u_lane (
      .clk(clk),
      .reset(reset),
      .outer(outer[i]),
      .inner(inner[i]),
      .enter(enter[i]),
      .exit(exit[i]),
      .illegal(illegal[i])
    );
  end
  // entries and exits net out before the clamp is applied
  always_comb nxt = SW'(count) + SW'(popcount(8'(enter))) - SW'(popcount(8'(exit)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      fault <= '0;
    end else begin
      overflow <= nxt > CAP_S;
      underflow <= nxt[SW-1];
      count <= (nxt > CAP_S) ? CNT_W'(CAPACITY) : nxt[SW-1] ? '0 : nxt[CNT_W-1:0];
      fault <= (fault & ~{N_LANES{clear_fault}}) | illegal;
    end
  assign full = count == CNT_W'(CAPACITY);
  assign empty = count == '0;
endmodule

// File: tb/tb_parking_lot_monitor.sv
// tb_parking_lot_monitor: directed and randomized lane scripts checked against a sample-history model
module tb_parking_lot_monitor;
  localparam int N = 2, CAP = 3, D = 2, CW = $clog2(CAP + 1), HL = D + 2;
  typedef struct {logic [1:0] p; int h;} seg_t;
  logic clk = 1'b0, reset = 1'b0, clear_fault = 1'b0;
  logic [N-1:0] outer = '0, inner = '0;
  logic [N-1:0] enter, exit, fault;
  logic [CW-1:0] count;
  logic full, empty, overflow, underflow;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_en0 = 0, n_en1 = 0, n_ovf = 0, en0_cyc = 0, saved;
  int left [N];
  int clr_cyc [N];
  bit rand_clr = 0;
  seg_t q0 [$];
  seg_t q1 [$];
  int m_count = 0, t;
  logic m_ovf = 0, m_udf = 0;
  logic [N-1:0] m_en = '0, m_ex = '0, m_ill = '0, m_fault = '0;
  int dir [N];
  int st [N];
  logic [1:0] mf [N];
  bit hist [N][2][HL];
  logic [1:0] raw;
  bit flip;

  parking_lot_monitor #(.N_LANES(N), .CAPACITY(CAP), .DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset), .outer(outer), .inner(inner), .clear_fault(clear_fault),
    .enter(enter), .exit(exit), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // expected pattern at step k (1..3) of an entry (dir>0) or exit (dir<0) passage
  function automatic logic [1:0] seq(input int d, input int k);
    if (k == 2) return 2'b11;
    if (k == 1) return d > 0 ? 2'b10 : 2'b01;
    return d > 0 ? 2'b01 : 2'b10;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_count = 0; m_ovf = 0; m_udf = 0;
      m_en = '0; m_ex = '0; m_ill = '0; m_fault = '0;
      for (int l = 0; l < N; l++) begin
        dir[l] = 0; st[l] = 0; mf[l] = 2'b00;
        for (int s = 0; s < 2; s++)
          for (int k = 0; k < HL; k++) hist[l][s][k] = 0;
      end
    end else begin
      t = m_count + $countones(m_en) - $countones(m_ex);
      m_ovf = t > CAP;
      m_udf = t < 0;
      m_count = t > CAP ? CAP : (t < 0 ? 0 : t);
      m_fault = (m_fault & ~{N{clear_fault}}) | m_ill;
      m_en = '0; m_ex = '0; m_ill = '0;
      for (int l = 0; l < N; l++) begin
        raw = {outer[l], inner[l]};
        for (int s = 0; s < 2; s++) begin
          for (int k = HL - 1; k > 0; k--) hist[l][s][k] = hist[l][s][k-1];
          hist[l][s][0] = raw[s];
          flip = 1;
          for (int k = 2; k <= D + 1; k++) if (hist[l][s][k] == mf[l][s]) flip = 0;
          if (flip) mf[l][s] = ~mf[l][s];
        end
        if (dir[l] == 0) begin
          if (mf[l] == 2'b10) begin dir[l] = 1; st[l] = 1; end
          else if (mf[l] == 2'b01) begin dir[l] = -1; st[l] = 1; end
          else if (mf[l] == 2'b11) m_ill[l] = 1;
        end else if (mf[l] == seq(dir[l], st[l])) begin
        end else if (st[l] < 3 && mf[l] == seq(dir[l], st[l] + 1)) st[l]++;
        else if (st[l] > 1 && mf[l] == seq(dir[l], st[l] - 1)) st[l]--;
        else begin
          if (mf[l] == 2'b00 && st[l] == 3) begin
            if (dir[l] > 0) m_en[l] = 1; else m_ex[l] = 1;
          end else if (!(mf[l] == 2'b00 && st[l] == 1)) m_ill[l] = 1;
          dir[l] = 0;
        end
      end
    end
    #1;
    check("enter", enter, m_en);
    check("exit", exit, m_ex);
    check("count", count, m_count);
    check("full", full, m_count == CAP);
    check("empty", empty, m_count == 0);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
    check("fault", fault, m_fault);
    if (enter[0]) begin n_en0++; en0_cyc = cyc; end
    if (enter[1]) n_en1++;
    if (overflow) n_ovf++;
  end

  task automatic push(input int l, input logic [1:0] p, input int h);
    seg_t s;
    s.p = p; s.h = h;
    if (l == 0) q0.push_back(s); else q1.push_back(s);
  endtask

  task automatic script(input int l, input int kind, input int h);
    case (kind)
      0: begin push(l, 2'b10, h); push(l, 2'b11, h); push(l, 2'b01, h); push(l, 2'b00, h); end
      1: begin push(l, 2'b01, h); push(l, 2'b11, h); push(l, 2'b10, h); push(l, 2'b00, h); end
      2: begin push(l, 2'b10, h); push(l, 2'b00, h); end
      3: begin push(l, 2'b10, h); push(l, 2'b11, h); push(l, 2'b10, h); push(l, 2'b00, h); end
      4: begin push(l, 2'b11, h); push(l, 2'b00, h); end
      default: begin push(l, 2'b10, 1); push(l, 2'b00, h); end
    endcase
  endtask

  task automatic tick();
    seg_t s;
    bit got;
    @(negedge clk);
    for (int l = 0; l < N; l++) begin
      got = 0;
      if (left[l] == 0) begin
        if (l == 0 && q0.size() > 0) begin s = q0.pop_front(); got = 1; end
        if (l == 1 && q1.size() > 0) begin s = q1.pop_front(); got = 1; end
        if (got) begin
          outer[l] = s.p[1]; inner[l] = s.p[0]; left[l] = s.h;
          if (s.p == 2'b00) clr_cyc[l] = cyc;
        end
      end
      if (left[l] > 0) left[l]--;
    end
    if (rand_clr) clear_fault = $urandom_range(0, 15) == 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || left[0] > 0 || left[1] > 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_bound", n < 3000, 1);
    repeat (D + 6) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int l = 0; l < N; l++) begin left[l] = 0; clr_cyc[l] = 0; end
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    reset = 1'b1;
    script(0, 0, 6);
    drain();
    check("t1_enters", n_en0, 1);
    check("t1_latency", en0_cyc - clr_cyc[0], 2 + D);
    check("t1_count", count, 1);
    check("t1_empty", empty, 0);
    script(1, 1, 6);
    drain();
    check("t2_count", count, 0);
    check("t2_empty", empty, 1);
    script(0, 2, 6);
    push(1, 2'b10, 1);
    push(1, 2'b00, 6);
    drain();
    check("t3_count", count, 0);
    check("t3_fault", fault, 0);
    check("t3_enters", n_en0, 1);
    repeat (3) script(0, 0, 5);
    drain();
    check("t4_count", count, 3);
    check("t4_full", full, 1);
    n_ovf = 0;
    script(0, 0, 5);
    script(1, 1, 5);
    drain();
    check("t4_net_count", count, 3);
    check("t4_net_ovf", n_ovf, 0);
    script(0, 0, 5);
    drain();
    check("t4_sat_count", count, 3);
    check("t4_ovf_pulses", n_ovf, 1);
    script(1, 4, 6);
    drain();
    check("t5_fault_set", fault, 2'b10);
    repeat (4) tick();
    check("t5_fault_held", fault, 2'b10);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    tick();
    check("t5_fault_clr", fault, 0);
    saved = n_en1;
    script(1, 1, 5);
    script(1, 0, 5);
    drain();
    check("t5_lane1_enter", n_en1 - saved, 1);
    check("t5_count", count, 3);
    saved = n_en0;
    push(0, 2'b10, 6);
    push(0, 2'b11, 40);
    repeat (14) tick();
    @(posedge clk);
    #3 reset = 1'b0;
    q0.delete(); q1.delete();
    left[0] = 0; left[1] = 0;
    outer = '0; inner = '0;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_enter", enter, 0);
    check("t6_fault", fault, 0);
    #9 reset = 1'b1;
    repeat (15) tick();
    check("t6_no_enter", n_en0 - saved, 0);
    check("t6_count_after", count, 0);
    rand_clr = 1;
    repeat (40) begin
      for (int l = 0; l < N; l++)
        if ($urandom_range(0, 3) != 0) begin
          push(l, 2'b00, $urandom_range(1, 4));
          script(l, $urandom_range(0, 5), $urandom_range(2, 6));
        end
      drain();
    end
    rand_clr = 0;
    clear_fault = 1'b0;
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
